// File: rtl/sin_nco_if.sv
// Control and sample bus of the sine/cosine NCO.
// The master drives the phase controls; the slave (the NCO) returns the samples.
interface sin_nco_if #(
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned PHASE_W = 24
);
  logic                      en;
  logic                      clr;
  logic                      freq_we;
  logic [PHASE_W-1:0]        freq_word;
  logic signed [OUT_W-1:0]   sin_out;
  logic signed [OUT_W-1:0]   cos_out;
  logic                      out_valid;
  logic                      out_wrap;

  modport master (
    output en, clr, freq_we, freq_word,
    input  sin_out, cos_out, out_valid, out_wrap
  );

  modport slave (
    input  en, clr, freq_we, freq_word,
    output sin_out, cos_out, out_valid, out_wrap
  );
endinterface

// File: rtl/sin_nco.sv
// Quarter-wave table NCO: phase accumulator, then capture / table read / sign apply.
// Produces sine and cosine at the same phase instant, one sample per enabled cycle.
module sin_nco #(
  parameter int unsigned        OUT_W     = 16,
  parameter int unsigned        PHASE_W   = 24,
  parameter int unsigned        LUT_AW    = 6,
  parameter logic [PHASE_W-1:0] FREQ_INIT = '0
) (
  input  logic     clk,
  input  logic     rst,
  sin_nco_if.slave bus
);

  localparam int unsigned N     = 1 << LUT_AW;
  localparam int unsigned MAG_W = OUT_W - 1;
  localparam int unsigned TOP_W = LUT_AW + 2;

  // Quarter-wave magnitudes sampled at bin centres, rounded half away from zero.
  function automatic logic [N*MAG_W-1:0] build_lut();
    logic [N*MAG_W-1:0] t;
    real amp;
    real x;
    real term;
    real s;
    t   = '0;
    amp = (2.0 ** (OUT_W - 1)) - 1.0;
    for (int i = 0; i < int'(N); i++) begin
      x    = 3.14159265358979323846 * real'(2 * i + 1) / real'(4 * int'(N));
      term = x;
      s    = x;
      for (int k = 1; k <= 12; k++) begin
        term = -term * x * x / real'((2 * k) * (2 * k + 1));
        s    = s + term;
      end
      t[i*int'(MAG_W) +: MAG_W] = MAG_W'($rtoi(amp * s + 0.5));
    end
    return t;
  endfunction

  localparam logic [N*MAG_W-1:0] LUT = build_lut();

  function automatic logic [MAG_W-1:0] lut_at(input logic [LUT_AW-1:0] addr);
    return LUT[int'(addr)*int'(MAG_W) +: MAG_W];
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                         input logic             neg);
    logic signed [OUT_W-1:0] v;
    v = signed'({1'b0, mag});
    return neg ? -v : v;
  endfunction

  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] phase_acc;
  logic               wrap_pend;

  logic [TOP_W-1:0]   s1_phase;
  logic               s1_valid;
  logic               s1_wrap;

  logic [MAG_W-1:0]   s2_sin_mag;
  logic [MAG_W-1:0]   s2_cos_mag;
  logic               s2_sin_neg;
  logic               s2_cos_neg;
  logic               s2_valid;
  logic               s2_wrap;

  logic signed [OUT_W-1:0] sin_q;
  logic signed [OUT_W-1:0] cos_q;
  logic                    valid_q;
  logic                    wrap_q;

  logic [PHASE_W:0]   sum_c;
  logic [1:0]         q_sin_c;
  logic [1:0]         q_cos_c;
  logic [LUT_AW-1:0]  idx_c;
  logic [LUT_AW-1:0]  sin_addr_c;
  logic [LUT_AW-1:0]  cos_addr_c;

  assign sum_c = {1'b0, phase_acc} + {1'b0, freq_reg};

  // Odd quadrants walk the table backwards; the upper half is negated.
  always_comb begin
    q_sin_c    = s1_phase[TOP_W-1 -: 2];
    idx_c      = s1_phase[LUT_AW-1:0];
    q_cos_c    = q_sin_c + 2'd1;
    sin_addr_c = q_sin_c[0] ? ~idx_c : idx_c;
    cos_addr_c = q_cos_c[0] ? ~idx_c : idx_c;
  end

  // Phase accumulator; wrap_pend marks that the next launched sample opens a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_reg  <= FREQ_INIT;
      phase_acc <= '0;
      wrap_pend <= 1'b1;
    end else begin
      if (bus.freq_we) freq_reg <= bus.freq_word;
      if (bus.clr) begin
        phase_acc <= '0;
        wrap_pend <= 1'b1;
      end else if (bus.en) begin
        phase_acc <= sum_c[PHASE_W-1:0];
        wrap_pend <= sum_c[PHASE_W];
      end
    end
  end

  // Stage 1: capture the pre-add phase (only the bits the decoder uses).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_phase <= '0;
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
    end else begin
      s1_valid <= bus.en & ~bus.clr;
      if (bus.en && !bus.clr) begin
        s1_phase <= phase_acc[PHASE_W-1 -: TOP_W];
        s1_wrap  <= wrap_pend;
      end
    end
  end

  // Stage 2: table read for both phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sin_mag <= '0;
      s2_cos_mag <= '0;
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
      s2_valid   <= 1'b0;
      s2_wrap    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_wrap  <= s1_wrap;
      if (s1_valid) begin
        s2_sin_mag <= lut_at(sin_addr_c);
        s2_cos_mag <= lut_at(cos_addr_c);
        s2_sin_neg <= q_sin_c[1];
        s2_cos_neg <= q_cos_c[1];
      end
    end
  end

  // Stage 3: sign apply; sample values hold between valid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= s2_valid;
      wrap_q  <= s2_valid & s2_wrap;
      if (s2_valid) begin
        sin_q <= apply_sign(s2_sin_mag, s2_sin_neg);
        cos_q <= apply_sign(s2_cos_mag, s2_cos_neg);
      end
    end
  end

  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.out_valid = valid_q;
  assign bus.out_wrap  = wrap_q;

endmodule

// File: tb/tb_sin_nco.sv
// Scoreboard bench for sin_nco: a trigonometric reference model predicts each
// launched sample; a negedge monitor pops and compares whatever the DUT emits.
module tb_sin_nco;

  localparam int unsigned OUT_W   = 16;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned LUT_AW  = 2;
  localparam int          PMOD    = 1 << PHASE_W;
  localparam int          SHIFT   = PHASE_W - LUT_AW - 2;
  localparam int          BINS    = 1 << (LUT_AW + 2);
  localparam int          AMP     = (1 << (OUT_W - 1)) - 1;
  localparam real         PI      = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  sin_nco_if #(.OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

  sin_nco #(
    .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .FREQ_INIT(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int s;
    int c;
    bit w;
    int launch;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   rst_edge = 0;
  int   last_s   = 0;
  int   last_c   = 0;

  // Reference model state
  int m_phase = 0;
  int m_freq  = 0;
  bit m_wrap  = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  // Sample of a full-period sine/cosine taken at the centre of the phase bin.
  function automatic int ref_wave(input int p, input bit is_cos);
    real ang;
    real v;
    ang = 2.0 * PI * (real'(p >> SHIFT) + 0.5) / real'(BINS);
    v   = real'(AMP) * (is_cos ? $cos(ang) : $sin(ang));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic drive(input bit r, input bit e, input bit c, input bit we, input int word);
    exp_t x;
    int   nxt;
    rst           = r;
    bus.en        = e;
    bus.clr       = c;
    bus.freq_we   = we;
    bus.freq_word = PHASE_W'(word);
    if (r) begin
      m_phase  = 0;
      m_freq   = 0;
      m_wrap   = 1'b1;
      rst_edge = cyc + 1;
    end else begin
      if (c) begin
        m_phase = 0;
        m_wrap  = 1'b1;
      end else if (e) begin
        x.s      = ref_wave(m_phase, 1'b0);
        x.c      = ref_wave(m_phase, 1'b1);
        x.w      = m_wrap;
        x.launch = cyc;
        x.due    = cyc + 3;
        sbq.push_back(x);
        nxt     = m_phase + m_freq;
        m_wrap  = (nxt >= PMOD);
        m_phase = nxt % PMOD;
      end
      if (we) m_freq = word % PMOD;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: drop samples killed by reset, then compare or check hold behaviour.
  always @(negedge clk) begin
    exp_t   e;
    int     s;
    int     c;
    longint pw;
    longint dev;
    while (sbq.size() > 0 && sbq[0].launch < rst_edge && sbq[0].due >= rst_edge)
      void'(sbq.pop_front());
    s = int'(bus.sin_out);
    c = int'(bus.cos_out);
    if (cyc == rst_edge) begin
      chk("reset_valid", longint'(bus.out_valid), 0);
      chk("reset_sin", s, 0);
      chk("reset_cos", c, 0);
      last_s = 0;
      last_c = 0;
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc, e.due);
        chk("sin", s, e.s);
        chk("cos", c, e.c);
        chk("wrap", longint'(bus.out_wrap), longint'(e.w));
        chk("range", ((s > AMP) || (s < -AMP) || (c > AMP) || (c < -AMP)) ? 1 : 0, 0);
        pw  = longint'(s) * s + longint'(c) * c;
        dev = pw - longint'(AMP) * AMP;
        if (dev < 0) dev = -dev;
        chk("power", (dev * 100 <= longint'(AMP) * AMP) ? 1 : 0, 1);
      end
      last_s = s;
      last_c = c;
    end else begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("missing_sample_due", cyc, e.due + 1000);
      end
      chk("hold_sin", s, last_s);
      chk("hold_cos", c, last_c);
    end
  end

  initial begin
    // Reset, then program 16 and run continuously across two wraps
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 16);
    repeat (40) drive(0, 1, 0, 0, 0);
    // Alternating enable
    repeat (8) begin
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    // Frequency change in the same cycle as an enabled add
    drive(0, 1, 0, 1, 64);
    repeat (12) drive(0, 1, 0, 0, 0);
    // Clear mid-period with enable asserted
    drive(0, 1, 0, 1, 16);
    repeat (5) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (10) drive(0, 1, 0, 0, 0);
    // Reset with samples in flight
    repeat (5) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 32);
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, int'($urandom_range(1, 255)));
    repeat (10) drive(0, 1, 0, 0, 0);
    // Random traffic
    repeat (400) begin
      drive(($urandom % 100) == 0,
            ($urandom % 4) != 0,
            ($urandom % 20) == 0,
            ($urandom % 15) == 0,
            int'($urandom_range(0, 255)));
    end
    repeat (6) drive(0, 0, 0, 0, 0);
    chk("drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
